seq_mult32: RTL and testbench
=============================

// Module: seq_mult32
// PURPOSE
//  Multi-cycle 32x32 -> 64-bit shift-and-add multiplier for the HW datapath.
//  Sits beside the 32-bit ALU and consumes the bitwise-AND cell: each cycle's partial
//  product is multiplicand AND {32{multiplier LSB}}, accumulated into a 64-bit product register.
// PARAMETERS
//  WIDTH   32   operand width; product is 2*WIDTH. Only 32 is verified.
// PORTS
//  clk         in   1    single clock, rising edge
//  reset       in   1    synchronous, active-high reset
//  start       in   1    request; sampled only in IDLE or DONE
//  a           in   32   multiplicand, captured on accepted start
//  b           in   32   multiplier, captured on accepted start
//  is_signed   in   1    only with MULT_SIGNED_EN; operands are two's complement when 1
//  busy        out  1    high from the cycle after accept until product is valid
//  done        out  1    one-cycle pulse; product valid in this cycle
//  product     out  64   result; held until the next accepted start
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, busy=0, done=0, product=0, count=0.
//  - States: IDLE -> CALC (start=1) -> [FIXUP] -> DONE -> IDLE, or -> CALC if start=1.
//  - Accept (IDLE/DONE, start=1): mcand<=a; prod<={32'b0,b}; count<=0. Next state CALC.
//  - CALC, each cycle: pp = mcand & {32{prod[0]}}; {c,s} = prod[63:32] + pp (33-bit);
//    prod <= {c, s, prod[31:1]}; count++. After count==31, go to DONE (or FIXUP).
//  - Carry bit c is never dropped. 0xFFFFFFFF*0xFFFFFFFF must not overflow.
//  - Latency: start sampled at edge E0; done=1 after edge E0+33 (unsigned build).
//  - busy=1 in CALC/FIXUP only. done=1 only in DONE. busy and done are never both 1.
//  - start while busy: ignored, no effect on operands or count.
//  - start in the DONE cycle: accepted. The next run begins with no idle bubble.
//  - reset mid-CALC: abort immediately, all outputs go to reset values. No done pulse.
//  - Operand zero: takes the full 32 cycles (no early exit); product=0.
// CONFIGURATION
//  MULT_SIGNED_EN defined:
//    - Port is_signed exists.
//    - If is_signed=1 at accept, |a| and |b| are loaded, and sign = a[31]^b[31] is latched.
//    - A FIXUP state (1 cycle) negates prod when sign=1, so latency is E0+34 for signed runs.
//    - Unsigned runs skip FIXUP (E0+33).
//    - 0x80000000 magnitude is treated as an unsigned 2^31. Result is correct.
//  MULT_SIGNED_EN undefined: no is_signed port, no FIXUP state; unsigned only.
// STRUCTURE
//  - Package mult_pkg holds:
//    - the state typedef (IDLE, CALC, FIXUP, DONE)
//    - MULT_W=32, PROD_W=64, CNT_W=5, LAST_CNT=5'd31
//  - Sub-module: the partial-product gate is one and32 instance (mcand, {32{prod[0]}}).
//    FSM, adder and shift stay in seq_mult32.
// TESTING
//  - 3*5: start 1 cycle -> busy 32 cycles, done pulse at E0+33, product=64'h0F.
//  - 0xFFFFFFFF*0xFFFFFFFF -> product=64'hFFFFFFFE_00000001 (carry path).
//  - start pulsed with a=7,b=9 at cycle 10 of a 2*3 run -> ignored; product=6, one done pulse.
//  - reset at CALC cycle 15 -> next cycle busy=0, done=0, product=0. A fresh 4*4 run gives 16.
//  - Back-to-back: start held through DONE of 2*3 (=6) -> immediately runs 10*10, product=100.
//  - MULT_SIGNED_EN, is_signed=1, a=-3, b=7 -> done at E0+34, product=64'hFFFFFFFF_FFFFFFEB.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         MULT_W   = 32;
    localparam int         PROD_W   = 64;
    localparam int         CNT_W    = 5;
    localparam logic [4:0] LAST_CNT = 5'd31;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [MULT_W-1:0] abs_mag(input logic [MULT_W-1:0] v);
        return v[MULT_W-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/seq_mult32_and32.sv
// Partial-product gate: bitwise AND of two 32-bit words.
module and32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] z
);

    assign z = x & y;

endmodule

// File: rtl/seq_mult32.sv
// 32x32 -> 64-bit shift-and-add multiplier, one multiplier bit per cycle.
// Optional signed operands when MULT_SIGNED_EN is defined.
import mult_pkg::*;

module seq_mult32 #(
    parameter int WIDTH = MULT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef MULT_SIGNED_EN
    input  logic                 is_signed,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t              state_r;
    logic [MULT_W-1:0]   mcand_r;
    logic [PROD_W-1:0]   prod_r;
    logic [CNT_W-1:0]    count_r;
    logic [MULT_W-1:0]   pp_s;
    logic [MULT_W:0]     sum_s;
`ifdef MULT_SIGNED_EN
    logic                sign_r;
`endif

    and32 u_pp (
        .x (mcand_r),
        .y ({MULT_W{prod_r[0]}}),
        .z (pp_s)
    );

    // Upper half plus partial product, keeping the carry out.
    always_comb begin
        sum_s = {1'b0, prod_r[PROD_W-1:MULT_W]} + {1'b0, pp_s};
    end

    // Control FSM, datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            mcand_r <= {MULT_W{1'b0}};
            prod_r  <= {PROD_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= {PROD_W{1'b0}};
`ifdef MULT_SIGNED_EN
            sign_r  <= 1'b0;
`endif
        end else begin
            // Status follows the state one cycle later, so done lines up with product.
            busy <= (state_r == CALC) || (state_r == FIXUP);
            done <= (state_r == DONE);
            case (state_r)
                IDLE, DONE: begin
                    if (state_r == DONE) begin
                        product <= prod_r;
                    end
                    if (start) begin
                        count_r <= {CNT_W{1'b0}};
                        state_r <= CALC;
`ifdef MULT_SIGNED_EN
                        if (is_signed) begin
                            mcand_r <= abs_mag(a);
                            prod_r  <= {{MULT_W{1'b0}}, abs_mag(b)};
                            sign_r  <= a[MULT_W-1] ^ b[MULT_W-1];
                        end else begin
                            mcand_r <= a;
                            prod_r  <= {{MULT_W{1'b0}}, b};
                            sign_r  <= 1'b0;
                        end
`else
                        mcand_r <= a;
                        prod_r  <= {{MULT_W{1'b0}}, b};
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    prod_r  <= {sum_s, prod_r[MULT_W-1:1]};
                    count_r <= count_r + 5'd1;
                    if (count_r == LAST_CNT) begin
`ifdef MULT_SIGNED_EN
                        state_r <= sign_r ? FIXUP : DONE;
`else
                        state_r <= DONE;
`endif
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIXUP: begin
                    prod_r  <= {PROD_W{1'b0}} - prod_r;
                    state_r <= DONE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult32.sv
// Directed self-checking bench for seq_mult32 (signed cases only with MULT_SIGNED_EN).
module tb_seq_mult32;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
`ifdef MULT_SIGNED_EN
    logic        is_signed;
`endif
    logic        busy;
    logic        done;
    logic [63:0] product;

    int checks;
    int errors;

    seq_mult32 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef MULT_SIGNED_EN
        .is_signed (is_signed),
`endif
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands before a rising edge; that edge is E0.
    task automatic launch(input logic [31:0] x, input logic [31:0] y, input bit hold);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Count edges until done, with a bound; no comparisons here.
    task automatic wait_done(output int n, output int busy_cnt, output bit got);
        n = 0; busy_cnt = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (product !== 64'd0) begin errors++; $display("FAIL reset_product: got %h expected 0", product); end
        reset = 1'b0;
    endtask

    task automatic test_unsigned(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp, input string name);
        int n, bc; bit got;
        launch(x, y, 1'b0);
        wait_done(n, bc, got);
        checks++; if (!got) begin errors++; $display("FAIL %s_timeout: no done within 100 cycles", name); end
        checks++; if (n !== 33) begin errors++; $display("FAIL %s_latency: got %0d expected 33", name, n); end
        checks++; if (bc !== 32) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected 32", name, bc); end
        checks++; if (product !== exp) begin errors++; $display("FAIL %s_product: got %h expected %h", name, product, exp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_with_done: got %b expected 0", name, busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_pulse_width: got %b expected 0", name, done); end
    endtask

    task automatic test_ignore_start();
        int n, pulses; bit got;
        launch(32'd2, 32'd3, 1'b0);
        n = 0; pulses = 0; got = 1'b0;
        while (n < 33) begin
            @(posedge clk); #1; n++;
            if (n == 9)  begin start = 1'b1; a = 32'd7; b = 32'd9; end
            if (n == 10) start = 1'b0;
            if (done) begin pulses++; got = 1'b1; end
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++; if (!got) begin errors++; $display("FAIL ignore_done_at_33: not seen"); end
        checks++; if (product !== 64'd6) begin errors++; $display("FAIL ignore_product: got %h expected 6", product); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_reset_mid();
        int n, bc, pulses; bit got;
        launch(32'd4, 32'd5, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
        checks++; if (product !== 64'd0) begin errors++; $display("FAIL midreset_product: got %h expected 0", product); end
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midreset_activity: got %0d expected 0", pulses); end
        launch(32'd4, 32'd4, 1'b0);
        wait_done(n, bc, got);
        checks++; if (!got || product !== 64'd16) begin errors++; $display("FAIL midreset_rerun: got %h expected 10", product); end
    endtask

    task automatic test_back_to_back();
        int n, n2, bc; bit got;
        launch(32'd2, 32'd3, 1'b1);
        n = 0; got = 1'b0;
        while (n < 34) begin
            @(posedge clk); #1; n++;
            if (n == 32) begin a = 32'd10; b = 32'd10; end
            if (n == 33) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", done); end
                checks++; if (product !== 64'd6) begin errors++; $display("FAIL b2b_first_product: got %h expected 6", product); end
                start = 1'b0;
            end
            if (n == 34) begin
                checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_no_bubble: got busy=%b done=%b expected busy=1 done=0", busy, done); end
            end
        end
        wait_done(n2, bc, got);
        checks++; if (!got || n2 !== 32) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 32", n2); end
        checks++; if (product !== 64'd100) begin errors++; $display("FAIL b2b_second_product: got %h expected 64", product); end
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp, input int lat, input string name);
        int n, bc; bit got;
        is_signed = 1'b1;
        launch(x, y, 1'b0);
        wait_done(n, bc, got);
        is_signed = 1'b0;
        checks++; if (!got || n !== lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, n, lat); end
        checks++; if (product !== exp) begin errors++; $display("FAIL %s_product: got %h expected %h", name, product, exp); end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
`ifdef MULT_SIGNED_EN
        is_signed = 1'b0;
`endif
        test_reset();
        test_unsigned(32'd3, 32'd5, 64'h0000_0000_0000_000F, "mul_3x5");
        test_unsigned(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "carry");
        test_unsigned(32'd0, 32'h0001_2345, 64'd0, "zero");
        test_unsigned(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "msb");
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef MULT_SIGNED_EN
        test_signed(32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 34, "s_neg3x7");
        test_signed(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 34, "s_minx1");
        test_signed(32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, "s_minxneg1");
        test_unsigned(32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB, "u_in_signed_build");
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
